// File: rtl/controller_input_conditioner_if.sv
// Button bus between the board inputs and the input conditioner.
// There is no valid/ready handshake on this bus. buttons_raw is a free-running level
// from the board. controller carries fire-and-forget pulses, each exactly one cycle
// wide; the piece mover must consume a pulse in the cycle it is high.
// buttons_held is a level. rp_state_dbg exposes the four repeat FSM states,
// two bits per button, with bit i in [2i+1:2i].
interface controller_input_conditioner_if;
  logic [3:0] buttons_raw;
  logic [3:0] controller;
  logic [3:0] buttons_held;
  logic [7:0] rp_state_dbg;

  modport master (
    output buttons_raw,
    input  controller,
    input  buttons_held,
    input  rp_state_dbg
  );

  modport slave (
    input  buttons_raw,
    output controller,
    output buttons_held,
    output rp_state_dbg
  );
endinterface

// File: rtl/controller_input_conditioner.sv
// Conditions four raw push-buttons into one-cycle move-command pulses.
// Each button is synchronised, debounced and then turned into a press pulse.
// Buttons whose REPEAT_MASK bit is set also auto-repeat while they are held.
// Left and right lock each other out while both are held.
module controller_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned REPEAT_DELAY    = 12_500_000,
  parameter int unsigned REPEAT_RATE     = 5_000_000,
  parameter logic [3:0]  REPEAT_MASK     = 4'b1011,
  parameter int unsigned CNT_W           = 24
) (
  input  logic                          clk,
  input  logic                          reset,
  controller_input_conditioner_if.slave cmd_if
);

  typedef enum logic [1:0] {
    RP_IDLE   = 2'd0,
    RP_DELAY  = 2'd1,
    RP_REPEAT = 2'd2
  } rp_state_e;

  // Terminal counts. A counter is compared against its terminal count before it
  // increments, so it never wraps.
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);

  logic [3:0]       sync1_q;
  logic [3:0]       sync2_q;
  logic [CNT_W-1:0] db_cnt_q [4];
  logic [CNT_W-1:0] db_cnt_d [4];
  logic [3:0]       held_q;
  logic [3:0]       held_d;
  rp_state_e        rp_state_q [4];
  rp_state_e        rp_state_d [4];
  logic [CNT_W-1:0] rp_cnt_q [4];
  logic [CNT_W-1:0] rp_cnt_d [4];
  logic [3:0]       pulse_raw;
  logic [3:0]       ctrl_q;
  logic [3:0]       ctrl_d;

  // Two-flop synchroniser on the asynchronous button inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= cmd_if.buttons_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: a new synchronised level is accepted only after it has held for
  // DEBOUNCE_CYCLES consecutive cycles. Any return to the current level restarts the count.
  always_comb begin
    held_d = held_q;
    for (int i = 0; i < 4; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != held_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          held_d[i]   = sync2_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      held_q <= '0;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
    end else begin
      held_q <= held_d;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  // Repeat FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        rp_state_q[i] <= RP_IDLE;
        rp_cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        rp_state_q[i] <= rp_state_d[i];
        rp_cnt_q[i]   <= rp_cnt_d[i];
      end
    end
  end

  // Repeat FSM next state. The FSM follows held_d, so a press or a release takes
  // effect in the same cycle as the buttons_held change.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rp_state_d[i] = rp_state_q[i];
      rp_cnt_d[i]   = '0;
      if (!held_d[i]) begin
        rp_state_d[i] = RP_IDLE;
      end else begin
        case (rp_state_q[i])
          RP_IDLE: begin
            // A non-repeating button stays here until it is released. The press
            // pulse comes from the held edge, so it fires only once per press.
            if (!held_q[i] && REPEAT_MASK[i]) rp_state_d[i] = RP_DELAY;
          end
          RP_DELAY: begin
            if (rp_cnt_q[i] == RD_LAST) rp_state_d[i] = RP_REPEAT;
            else                        rp_cnt_d[i]   = rp_cnt_q[i] + 1'b1;
          end
          RP_REPEAT: begin
            if (rp_cnt_q[i] != RR_LAST) rp_cnt_d[i] = rp_cnt_q[i] + 1'b1;
          end
          default: rp_state_d[i] = RP_IDLE;
        endcase
      end
    end
  end

  // Repeat FSM output. A button raises its pulse request on the press edge and on
  // each repeat terminal count. A release never produces a pulse.
  always_comb begin
    pulse_raw = '0;
    for (int i = 0; i < 4; i++) begin
      if (held_d[i]) begin
        case (rp_state_q[i])
          RP_IDLE:   pulse_raw[i] = !held_q[i];
          RP_DELAY:  pulse_raw[i] = (rp_cnt_q[i] == RD_LAST);
          RP_REPEAT: pulse_raw[i] = (rp_cnt_q[i] == RR_LAST);
          default:   pulse_raw[i] = 1'b0;
        endcase
      end
    end
  end

  // Left/right lockout. The FSMs keep counting underneath, and only the pulses are masked.
  always_comb begin
    ctrl_d = pulse_raw;
    if (held_d[0] && held_d[1]) ctrl_d[1:0] = 2'b00;
  end

  // Registered command pulses, aligned with the buttons_held register.
  always_ff @(posedge clk) begin
    if (reset) ctrl_q <= '0;
    else       ctrl_q <= ctrl_d;
  end

  // Outputs and FSM state visibility.
  always_comb begin
    cmd_if.controller   = ctrl_q;
    cmd_if.buttons_held = held_q;
    for (int i = 0; i < 4; i++) cmd_if.rp_state_dbg[2*i +: 2] = rp_state_q[i];
  end

endmodule

// File: tb/tb_controller_input_conditioner.sv
// Testbench for controller_input_conditioner with short debounce and repeat timings.
// The reference model treats debounce as "the last D synchronised samples all
// differ from the held level". It treats repeat as a function of the time elapsed
// since the press.
module tb_controller_input_conditioner;
  localparam int         D    = 4;
  localparam int         RD   = 10;
  localparam int         RR   = 3;
  localparam int         CW   = 24;
  localparam logic [3:0] MASK = 4'b1011;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  controller_input_conditioner_if bus ();

  controller_input_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_RATE     (RR),
    .REPEAT_MASK     (MASK),
    .CNT_W           (CW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .cmd_if (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int cyc     = 0;

  // reference model state
  logic [3:0] m_s1, m_s2, m_held;
  logic [3:0] m_win[$];
  int         m_age[4];

  // pulse tracking
  int pcnt[4];
  int first[4];
  int watch_bit = 0;
  int pt_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_s1 = '0; m_s2 = '0; m_held = '0;
    m_win.delete();
    for (int k = 0; k < D; k++) m_win.push_back(4'h0);
    for (int b = 0; b < 4; b++) m_age[b] = 0;
  endtask

  // One clock edge of the reference model. It returns {held, controller} for after the edge.
  task automatic model_edge(input logic rst, input logic [3:0] raw);
    logic [3:0] nh;
    logic [3:0] ctl;
    bit all_diff;
    ctl = '0;
    if (rst) begin
      model_clear();
    end else begin
      m_win.push_back(m_s2);
      void'(m_win.pop_front());
      nh = m_held;
      for (int b = 0; b < 4; b++) begin
        all_diff = 1;
        foreach (m_win[k]) if (m_win[k][b] == m_held[b]) all_diff = 0;
        if (all_diff) nh[b] = ~m_held[b];
      end
      m_s2 = m_s1;
      m_s1 = raw;
      for (int b = 0; b < 4; b++) begin
        if (nh[b] && !m_held[b]) begin
          ctl[b] = 1'b1;
          m_age[b] = 0;
        end else if (nh[b]) begin
          m_age[b]++;
          if (MASK[b] && m_age[b] >= RD && ((m_age[b] - RD) % RR) == 0) ctl[b] = 1'b1;
        end else begin
          m_age[b] = 0;
        end
      end
      if (nh[0] && nh[1]) ctl[1:0] = 2'b00;
      m_held = nh;
    end
    exp_q.push_back({m_held, ctl});
  endtask

  task automatic clear_track();
    for (int b = 0; b < 4; b++) begin
      pcnt[b]  = 0;
      first[b] = -1;
    end
    pt_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock edge, step the model, and compare the DUT with the model 1 ns after the edge.
  task automatic tick(input string tag);
    logic [7:0] exp;
    @(posedge clk);
    model_edge(reset, bus.buttons_raw);
    cyc++;
    #1;
    exp = exp_q.pop_front();
    check(tag, {24'h0, bus.buttons_held, bus.controller}, {24'h0, exp});
    for (int b = 0; b < 4; b++) begin
      if (bus.controller[b]) begin
        pcnt[b]++;
        if (first[b] < 0) first[b] = cyc;
        if (b == watch_bit) pt_q.push_back(cyc);
      end
    end
  endtask

  task automatic ticks(input int n, input string tag);
    for (int k = 0; k < n; k++) tick(tag);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int t, rel;
    logic [3:0] r;
    reset = 1'b1;
    bus.buttons_raw = 4'h0;
    model_clear();
    clear_track();
    ticks(3, "init");

    // Reset with every button held. Outputs stay 0 during reset, and the press
    // pulses come 6 cycles after release. Left and right are both held, so the lockout masks their pulses.
    bus.buttons_raw = 4'hF;
    ticks(2, "reset_hold");
    reset = 1'b0;
    rel = cyc;
    clear_track();
    ticks(8, "reset_release");
    check("reset_first_drop", 32'(first[3] - rel), 32'd6);
    check("reset_first_rot",  32'(first[2] - rel), 32'd6);
    check("reset_lr_locked",  32'(pcnt[0] + pcnt[1]), 32'd0);
    bus.buttons_raw = 4'h0;
    ticks(D + 8, "reset_drain");

    // Bounce on left, then a steady hold.
    clear_track();
    for (int ph = 0; ph < 10; ph++) begin
      bus.buttons_raw[0] = (ph % 2 == 0);
      ticks(2, "bounce");
    end
    bus.buttons_raw[0] = 1'b1;
    t = cyc;
    ticks(8, "bounce_hold");
    check("bounce_count", 32'(pcnt[0]), 32'd1);
    check("bounce_delay", 32'(first[0] - t), 32'd6);
    bus.buttons_raw = 4'h0;
    ticks(10, "bounce_drain");

    // Drop repeats at press + 6, then after 10 cycles, then every 3 cycles.
    clear_track();
    watch_bit = 3;
    bus.buttons_raw[3] = 1'b1;
    t = cyc;
    ticks(40, "repeat_hold");
    bus.buttons_raw[3] = 1'b0;
    rel = cyc;
    ticks(12, "repeat_release");
    check("repeat_p0", 32'(pt_q[0] - t), 32'd6);
    check("repeat_p1", 32'(pt_q[1] - t), 32'd16);
    check("repeat_p2", 32'(pt_q[2] - t), 32'd19);
    // Pulses come at t+6 and at t+16+3k up to rel+5 = t+45, which makes 11 in total.
    check("repeat_count", 32'(pcnt[3]), 32'd11);
    check("repeat_last_before_fall", 32'(pt_q[pt_q.size()-1] < rel + 6), 32'd1);

    // Rotate never repeats.
    clear_track();
    bus.buttons_raw[2] = 1'b1;
    ticks(40, "norep_hold");
    bus.buttons_raw[2] = 1'b0;
    ticks(12, "norep_release");
    check("norep_count", 32'(pcnt[2]), 32'd1);

    // Lockout: hold left, add right, then release left.
    clear_track();
    watch_bit = 1;
    bus.buttons_raw[0] = 1'b1;
    ticks(20, "lock_left");
    bus.buttons_raw[1] = 1'b1;
    ticks(30, "lock_both");
    bus.buttons_raw[0] = 1'b0;
    rel = cyc;
    ticks(30, "lock_right");
    check("lock_right_after_left_fall", 32'(pt_q[0] >= rel + 6), 32'd1);
    check("lock_right_cadence", 32'(pt_q[1] - pt_q[0]), 32'(RR));
    bus.buttons_raw = 4'h0;
    ticks(12, "lock_drain");

    // Reset in the middle of the repeat delay.
    clear_track();
    bus.buttons_raw[0] = 1'b1;
    t = cyc;
    ticks(11, "middelay_press");
    reset = 1'b1;
    ticks(2, "middelay_reset");
    reset = 1'b0;
    rel = cyc;
    ticks(12, "middelay_after");
    check("middelay_count", 32'(pcnt[0]), 32'd2);
    check("middelay_first", 32'(first[0] - t), 32'd6);
    bus.buttons_raw = 4'h0;
    ticks(12, "middelay_drain");
    check("middelay_fresh_seen", 32'(rel > t), 32'd1);

    // Random buttons with occasional resets.
    r = 4'h0;
    for (int k = 0; k < 600; k++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(15) == 0) r[b] = ~r[b];
      bus.buttons_raw = r;
      reset = ($urandom_range(149) == 0);
      tick("random");
    end
    reset = 1'b0;
    bus.buttons_raw = 4'h0;
    ticks(15, "final_drain");

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
